// File: rtl/uart_tx_beacon.sv
// Repeating 8N1 UART beacon: sends TX_BYTE, idles GAP_CYCLES, repeats forever.
// Define TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_beacon #(
  parameter int          CLK_HZ       = 12000000,
  parameter int          BAUD         = 115200,
  parameter int          CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter logic [7:0]  TX_BYTE      = 8'h9A,
  parameter int          GAP_CYCLES   = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tx_done,
  output logic test_pin,
  output logic tx_pin
);

  localparam int BIT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_GAP,
    S_START,
    S_DATA,
`ifdef TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             tick_q, tick_d;
  logic             bit_end;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_GAP;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
      tick_q    <= tick_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    bit_end   = (bit_cnt_q == BIT_LAST);

    if (state_q != S_GAP) begin
      bit_cnt_d = bit_end ? '0 : bit_cnt_q + 1'b1;
    end

    case (state_q)
      S_GAP: begin
        tx_d = 1'b1;
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = S_START;
          tx_d      = 1'b0;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          idx_d     = '0;
          shift_d   = TX_BYTE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
`ifdef TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^TX_BYTE;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          // The tx_done cycle is already the first idle cycle of the gap.
          state_d   = S_GAP;
          tx_d      = 1'b1;
          done_d    = 1'b1;
          gap_cnt_d = GAP_W'(1);
        end
      end
      default: begin
        state_d   = S_GAP;
        tx_d      = 1'b1;
        bit_cnt_d = '0;
        gap_cnt_d = '0;
      end
    endcase

    tick_d = (state_d != S_GAP) && (bit_cnt_d == '0);
  end

  assign tx_pin   = tx_q;
  assign tx_done  = done_q;
  assign test_pin = tick_q;

endmodule

// File: tb/tb_uart_tx_beacon.sv
// Directed bench for uart_tx_beacon: default 8N1 instance plus a small
// fast instance (CLKS_PER_BIT=4, GAP_CYCLES=2, TX_BYTE=8'h01).
module tb_uart_tx_beacon;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n, rst2_n;
  logic tx1, done1, test1;
  logic tx2, done2, test2;
  logic sel;
  logic obs_tx, obs_done, obs_test;

  int pass_cnt  = 0;
  int total_cnt = 0;

  uart_tx_beacon dut_def (
    .clk      (clk),
    .rst_n    (rst1_n),
    .tx_done  (done1),
    .test_pin (test1),
    .tx_pin   (tx1)
  );

  uart_tx_beacon #(
    .CLKS_PER_BIT (4),
    .GAP_CYCLES   (2),
    .TX_BYTE      (8'h01)
  ) dut_ovr (
    .clk      (clk),
    .rst_n    (rst2_n),
    .tx_done  (done2),
    .test_pin (test2),
    .tx_pin   (tx2)
  );

  always_comb begin
    obs_tx   = sel ? tx2   : tx1;
    obs_done = sel ? done2 : done1;
    obs_test = sel ? test2 : test1;
  end

  // Step edges until the line falls; n = edges taken, -1 on timeout.
  task automatic wait_fall(input int max_cycles, output int n, output int dones);
    n     = -1;
    dones = 0;
    for (int k = 1; k <= max_cycles; k++) begin
      @(posedge clk); #1;
      if (obs_done === 1'b1) dones++;
      if (obs_tx === 1'b0) begin
        n = k;
        break;
      end
    end
  endtask

  // Called with the falling start edge already sampled (i = 0).
  task automatic walk_frame(input string name, input int cpb, input int nslots,
                            input logic [10:0] bits);
    int   tx_err, tick_err, done_err;
    int   len;
    logic exp_tx, exp_tick, exp_done;
    tx_err = 0; tick_err = 0; done_err = 0;
    len = cpb * nslots;
    for (int i = 0; i <= len + 1; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      exp_tx   = (i < len) ? bits[i / cpb] : 1'b1;
      exp_tick = (i < len) && ((i % cpb) == 0);
      exp_done = (i == len);
      if (obs_tx   !== exp_tx)   tx_err++;
      if (obs_test !== exp_tick) tick_err++;
      if (obs_done !== exp_done) done_err++;
    end
    total_cnt++;
    if (tx_err != 0) $display("FAIL %s_line: %0d cycles wrong, required 0", name, tx_err);
    else pass_cnt++;
    total_cnt++;
    if (tick_err != 0) $display("FAIL %s_test_pin: %0d cycles wrong, required 0", name, tick_err);
    else pass_cnt++;
    total_cnt++;
    if (done_err != 0) $display("FAIL %s_tx_done: %0d cycles wrong, required 0 (pulse at +%0d)", name, done_err, len);
    else pass_cnt++;
    $display("frame %s: %0d slots of %0d cycles walked", name, nslots, cpb);
  endtask

  task automatic test_reset();
    int bad_tx, bad_done, bad_test;
    bad_tx = 0; bad_done = 0; bad_test = 0;
    rst1_n = 1'b0;
    rst2_n = 1'b0;
    sel    = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (tx1   !== 1'b1) bad_tx++;
      if (done1 !== 1'b0) bad_done++;
      if (test1 !== 1'b0) bad_test++;
    end
    total_cnt++;
    if (bad_tx != 0) $display("FAIL reset_tx_pin: %0d cycles not 1", bad_tx); else pass_cnt++;
    total_cnt++;
    if (bad_done != 0) $display("FAIL reset_tx_done: %0d cycles not 0", bad_done); else pass_cnt++;
    total_cnt++;
    if (bad_test != 0) $display("FAIL reset_test_pin: %0d cycles not 0", bad_test); else pass_cnt++;
    $display("reset held 5 cycles");
  endtask

  task automatic test_first_frame();
    int n, d;
    rst1_n = 1'b1;
    wait_fall(1500, n, d);
    total_cnt++;
    if (n !== 1001) $display("FAIL first_fall: at edge %0d after release, required 1001", n);
    else pass_cnt++;
    total_cnt++;
    if (d !== 0) $display("FAIL first_gap_done: %0d pulses, required 0", d);
    else pass_cnt++;
    walk_frame("first", 104, 10, 11'b11100110100);
  endtask

  task automatic test_repeat();
    int n, d, dones, ticks;
    wait_fall(1500, n, d);
    total_cnt++;
    if (n + 1041 !== 2040) $display("FAIL second_fall: %0d cycles after first, required 2040", n + 1041);
    else pass_cnt++;
    dones = 0;
    ticks = 0;
    for (int k = 1; k <= 4080; k++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) dones++;
      if (test1 === 1'b1) ticks++;
    end
    total_cnt++;
    if (dones !== 2) $display("FAIL repeat_done_count: %0d, required 2", dones); else pass_cnt++;
    total_cnt++;
    if (ticks !== 20) $display("FAIL repeat_tick_count: %0d, required 20", ticks); else pass_cnt++;
    total_cnt++;
    if (tx1 !== 1'b0) $display("FAIL third_fall: line %0b, required 0", tx1); else pass_cnt++;
    $display("repeat window 4080 cycles: %0d done pulses, %0d ticks", dones, ticks);
  endtask

  // Entered at the start-bit edge of a frame.
  task automatic test_mid_reset();
    int n, d;
    repeat (450) begin
      @(posedge clk); #1;
    end
    total_cnt++;
    if (tx1 !== 1'b1) $display("FAIL data_bit3: line %0b, required 1", tx1); else pass_cnt++;
    rst1_n = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if ({tx1, done1, test1} !== 3'b100)
      $display("FAIL mid_reset_outputs: tx/done/test=%03b, required 100", {tx1, done1, test1});
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    rst1_n = 1'b1;
    wait_fall(1500, n, d);
    total_cnt++;
    if (n !== 1001) $display("FAIL restart_fall: at edge %0d, required 1001", n); else pass_cnt++;
    total_cnt++;
    if (d !== 0) $display("FAIL aborted_frame_done: %0d pulses, required 0", d); else pass_cnt++;
    walk_frame("restart", 104, 10, 11'b11100110100);
    wait_fall(1500, n, d);
    repeat (10) begin
      @(posedge clk); #1;
    end
    total_cnt++;
    if (tx1 !== 1'b0) $display("FAIL start_bit_level: line %0b, required 0", tx1); else pass_cnt++;
    rst1_n = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (tx1 !== 1'b1) $display("FAIL abort_start_line: line %0b, required 1", tx1); else pass_cnt++;
    $display("mid-frame resets applied in data bit 3 and start bit");
  endtask

  task automatic test_override();
    int n, d, nslots;
`ifdef TX_PARITY_EN
    nslots = 11;
`else
    nslots = 10;
`endif
    sel    = 1'b1;
    rst2_n = 1'b1;
    wait_fall(20, n, d);
    total_cnt++;
    if (n !== 3) $display("FAIL ovr_first_fall: at edge %0d, required 3", n); else pass_cnt++;
    walk_frame("override", 4, nslots, 11'b11000000010);
    wait_fall(20, n, d);
    total_cnt++;
    if (n !== 1) $display("FAIL ovr_gap: fall %0d edges after walk, required 1", n); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_repeat();
    test_mid_reset();
    test_override();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_beacon.md
Name: uart_tx_beacon

Overview:
- Board-level top for the iCE40-HX8K breakout UART demo.
- Transmits a fixed byte repeatedly on the UART TX pin, framed 8N1, with an idle gap between frames.
- Contains the baud-rate divider, the TX shift state machine and the frame-repeat sequencer.
- Exposes a frame-complete strobe and a bit-timing debug pin for probing on the board.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz (breakout board oscillator).
- BAUD, 115200, line rate in bits/s.
- CLKS_PER_BIT, CLK_HZ/BAUD (integer division, 104 at defaults), clock cycles per bit period; must be >= 2.
- TX_BYTE, 8'h9A, byte transmitted in every frame.
- GAP_CYCLES, 1000, idle-high cycles after reset release and between consecutive frames; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- tx_done  output  1  one-cycle high pulse when a frame's stop bit completes.
- test_pin  output  1  bit-tick strobe: high for the first clock of every bit period (start, data, parity, stop).
- tx_pin  output  1  UART serial line; idles high.

Behaviour:
- Reset: rst_n sampled low at a rising edge drives all outputs and state on that edge.
  - tx_pin=1, tx_done=0, test_pin=0.
  - State=GAP, all counters=0.
- Reset applied mid-frame aborts the frame immediately: line goes high, no tx_done.
- States: GAP -> START -> DATA -> [PARITY] -> STOP -> GAP.
- GAP:
  - tx_pin=1 for exactly GAP_CYCLES cycles, then enter START.
  - The first start bit begins GAP_CYCLES cycles after the first edge with rst_n=1.
- START: tx_pin=0 for CLKS_PER_BIT cycles.
- DATA:
  - The shift register is loaded with TX_BYTE on entry to START.
  - 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - A 3-bit index counts 0..7; after bit 7 go to PARITY (if enabled) or STOP.
- STOP: tx_pin=1 for CLKS_PER_BIT cycles.
- tx_done: high for exactly one cycle, the first cycle after the stop bit period, coinciding with entry to GAP.
- Frame length: 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
- Frame period: frame length + GAP_CYCLES.
- Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps. test_pin=1 when the counter is 0 in START/DATA/PARITY/STOP; otherwise 0.
- Outputs are registered; tx_pin changes only on bit boundaries, with no glitches.
- Frames repeat indefinitely while rst_n=1. There are no external inputs besides clk and rst_n.

Optional Feature:
- Macro: TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx_pin = even parity of TX_BYTE (XOR of the 8 bits) for CLKS_PER_BIT cycles.
  - test_pin also strobes at the start of the parity bit.
  - tx_done is delayed accordingly.
- Undefined:
  - No PARITY state or logic is generated.
  - Pure 8N1 framing.

Test Plan:
- Reset hold: rst_n=0 for 5 cycles -> tx_pin=1, tx_done=0, test_pin=0 throughout.
- Defaults, release reset: tx_pin stays 1 for 1000 cycles, then falls.
  - Line sequence in 104-cycle slots: 0 (start), then data 0,1,0,1,1,0,0,1, then 1 (stop).
  - tx_done pulses once, 1040 cycles after the falling edge.
- Repeat: the second start bit falls exactly 2040 cycles after the first. Over a 100000-cycle run, 49 tx_done pulses occur.
- test_pin: exactly 10 one-cycle pulses per frame, spaced 104 cycles apart, the first coinciding with the start-bit falling edge.
- Reset mid-frame: assert rst_n=0 during data bit 3 -> tx_pin=1 on the next edge, no tx_done.
  - After release, a full new frame starts after 1000 cycles.
- Override CLKS_PER_BIT=4, GAP_CYCLES=2, TX_BYTE=8'h01, with TX_PARITY_EN -> start 0, data 1,0,0,0,0,0,0,0, parity 1, stop 1.
  - tx_done fires 44 cycles after the start-bit falling edge.
